taxi_qsfp_mod_ctrl: RTL and testbench
=====================================

// Module: taxi_qsfp_mod_ctrl
// PURPOSE
//  Per-cage QSFP28 module management sequencer for the 2-cage 25G MAC design; one instance serves all cages.
//  Replaces the static tie-offs of modsell/resetl/lpmode with: presence debounce -> timed reset -> t_init wait -> ready.
//  Reports per-cage present/ready/interrupt status to the management logic.
//  Cages sequence independently; all cage pins are asynchronous and are 2-flop synchronised inside.
// PARAMETERS
//  CNT            2          number of QSFP cages
//  DEBOUNCE_CYC   125000     cycles modprsl must stay low before the module counts as present (1 ms @125 MHz)
//  RESET_CYC      1250       cycles resetl is held low (10 us @125 MHz)
//  INIT_CYC       250000000  cycles waited after resetl deasserts before ready (t_init 2 s); counter width = $clog2(max+1)
// PORTS
//  clk            in   1      management clock (clk_125mhz)
//  rst_n          in   1      asynchronous, active-low reset
//  enable         in   CNT    per-cage enable; 0 forces the cage to ABSENT
//  reset_req      in   CNT    single-cycle pulse: re-run the reset sequence
//  lpmode_req     in   CNT    requested low-power mode, applied only in READY
//  sel_req        in   CNT    I2C select request (drives modsell low)
//  qsfp_modprsl   in   CNT    module present, active low (async)
//  qsfp_intl      in   CNT    module interrupt, active low (async)
//  qsfp_resetl    out  CNT    module reset, active low
//  qsfp_lpmode    out  CNT    module low-power mode
//  qsfp_modsell   out  CNT    module select, active low
//  present        out  CNT    debounced presence
//  ready          out  CNT    module initialised and usable
//  int_pending    out  CNT    synchronised interrupt, gated by ready
//  state          out  3*CNT  per-cage FSM state, for debug
// BEHAVIOUR
//  Reset (rst_n=0): every output is registered.
//   - qsfp_resetl=0, qsfp_lpmode=1, qsfp_modsell=1.
//   - present=0, ready=0, int_pending=0, state=ABSENT.
//   - Synchroniser flops reset to 1, i.e. the idle levels.
//  Synchronisers: 2 flops. A pin change is visible as prs_s/int_s on the 2nd clk edge.
//  State encoding: ABSENT=0, DEBOUNCE=1, RESET=2, INIT=3, READY=4. Each cage has its own timer.
//   - ABSENT: resetl=0, lpmode=1.
//       Exit to DEBOUNCE when enable=1 and prs_s=0; timer cleared on entry.
//   - DEBOUNCE: increments the timer each cycle prs_s=0.
//       prs_s=1 for one cycle returns the cage to ABSENT (glitch rejected).
//       Timer==DEBOUNCE_CYC-1 -> RESET, present=1.
//   - RESET: resetl=0 for exactly RESET_CYC cycles, then INIT.
//   - INIT: resetl=1 and lpmode=1 for exactly INIT_CYC cycles, then READY.
//   - READY: ready=1, lpmode follows lpmode_req with 1 cycle latency.
//  Exits from any non-ABSENT state (highest priority first, same cycle):
//   - prs_s=1 or enable=0 -> ABSENT; present=0, ready=0, resetl=0, lpmode=1 on the next edge.
//   - reset_req in RESET, INIT or READY -> RESET with timer cleared; ready drops next cycle. Ignored in ABSENT and DEBOUNCE.
//  Latency: debounce window ends -> resetl low on the next edge.
//   modprsl low -> ready = 2 (sync) + DEBOUNCE_CYC + RESET_CYC + INIT_CYC + 1 cycles.
//  int_pending = ready & ~int_s, registered. It is 0 outside READY.
//  qsfp_modsell = ~(sel_req & present), registered. It is 1 whenever the module is not present.
//  Timers saturate, never wrap. Cages share no state; simultaneous events on different cages are independent.
//  rst_n asserted mid-sequence returns everything to the reset values immediately (async). No partial state survives.
// TESTING (DEBOUNCE_CYC=4, RESET_CYC=8, INIT_CYC=16, CNT=2)
//  1 Insert cage0 (modprsl 1->0), enable=3.
//     -> present[0]=1, then resetl[0] low exactly 8 cycles, then ready[0]=1 exactly 2+4+8+16+1=31 cycles after insertion.
//     -> Cage1 stays ABSENT with resetl=0.
//  2 modprsl pulses high for 1 cycle during DEBOUNCE -> state returns to ABSENT and the debounce restarts. No reset pulse is issued.
//  3 In READY, pull modprsl high -> 3 cycles later ready=0, resetl=0, lpmode=1, modsell=1 and state=ABSENT.
//  4 reset_req pulse in READY -> ready=0 next cycle, resetl low 8 cycles, ready again after a further 8+16 cycles.
//  5 READY with lpmode_req toggled 0->1->0 -> qsfp_lpmode follows with 1 cycle lag.
//     -> intl low gives int_pending=1 after 3 cycles; intl low in INIT gives int_pending=0.
//  6 Deassert rst_n while in INIT -> all outputs take their reset values without waiting for clk.
//     -> After release the cage re-runs the full sequence from ABSENT.

Source files
------------

// File: rtl/taxi_qsfp_mod_ctrl.sv
// Per-cage QSFP28 management sequencer: presence debounce, timed module reset,
// t_init wait, then ready. Each cage runs its own FSM and timer.
module taxi_qsfp_mod_ctrl #(
  parameter int CNT          = 2,
  parameter int DEBOUNCE_CYC = 125000,
  parameter int RESET_CYC    = 1250,
  parameter int INIT_CYC     = 250000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT-1:0]   enable,
  input  logic [CNT-1:0]   reset_req,
  input  logic [CNT-1:0]   lpmode_req,
  input  logic [CNT-1:0]   sel_req,
  input  logic [CNT-1:0]   qsfp_modprsl,
  input  logic [CNT-1:0]   qsfp_intl,
  output logic [CNT-1:0]   qsfp_resetl,
  output logic [CNT-1:0]   qsfp_lpmode,
  output logic [CNT-1:0]   qsfp_modsell,
  output logic [CNT-1:0]   present,
  output logic [CNT-1:0]   ready,
  output logic [CNT-1:0]   int_pending,
  output logic [3*CNT-1:0] state
);

  localparam int MAX_AB  = (DEBOUNCE_CYC > RESET_CYC) ? DEBOUNCE_CYC : RESET_CYC;
  localparam int MAX_CYC = (INIT_CYC > MAX_AB) ? INIT_CYC : MAX_AB;
  localparam int TW      = $clog2(MAX_CYC + 1);

  localparam logic [TW-1:0] DEB_LAST  = TW'(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] RST_LAST  = TW'(RESET_CYC - 1);
  localparam logic [TW-1:0] INIT_LAST = TW'(INIT_CYC - 1);
  localparam logic [TW-1:0] TMR_MAX   = {TW{1'b1}};

  typedef enum logic [2:0] {
    ST_ABSENT   = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RESET    = 3'd2,
    ST_INIT     = 3'd3,
    ST_READY    = 3'd4
  } state_t;

  for (genvar gi = 0; gi < CNT; gi++) begin : g_cage
    logic          prs_s1_q, prs_s_q;
    logic          int_s1_q, int_s_q;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          resetl_q, resetl_d;
    logic          lpmode_q, lpmode_d;
    logic          modsell_q, modsell_d;
    logic          present_q, present_d;
    logic          ready_q, ready_d;
    logic          intp_q, intp_d;

    // Synchronisers idle high so an unplugged cage looks absent out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        prs_s1_q <= 1'b1;
        prs_s_q  <= 1'b1;
        int_s1_q <= 1'b1;
        int_s_q  <= 1'b1;
      end else begin
        prs_s1_q <= qsfp_modprsl[gi];
        prs_s_q  <= prs_s1_q;
        int_s1_q <= qsfp_intl[gi];
        int_s_q  <= int_s1_q;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q   <= ST_ABSENT;
        timer_q   <= '0;
        resetl_q  <= 1'b0;
        lpmode_q  <= 1'b1;
        modsell_q <= 1'b1;
        present_q <= 1'b0;
        ready_q   <= 1'b0;
        intp_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        timer_q   <= timer_d;
        resetl_q  <= resetl_d;
        lpmode_q  <= lpmode_d;
        modsell_q <= modsell_d;
        present_q <= present_d;
        ready_q   <= ready_d;
        intp_q    <= intp_d;
      end
    end

    always_comb begin
      state_d = state_q;
      timer_d = timer_q;

      case (state_q)
        ST_ABSENT: begin
          if (enable[gi] && !prs_s_q) begin
            state_d = ST_DEBOUNCE;
            timer_d = '0;
          end
        end
        ST_DEBOUNCE: begin
          if (timer_q == DEB_LAST) begin
            state_d = ST_RESET;
            timer_d = '0;
          end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_RESET: begin
          if (timer_q == RST_LAST) begin
            state_d = ST_INIT;
            timer_d = '0;
          end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_INIT: begin
          if (timer_q == INIT_LAST) begin
            state_d = ST_READY;
            timer_d = '0;
          end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + 1'b1;
          end
        end
        ST_READY: begin
          state_d = ST_READY;
        end
        default: begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end
      endcase

      // Removal/disable beats a reset request; both override the normal flow.
      if (state_q != ST_ABSENT) begin
        if (prs_s_q || !enable[gi]) begin
          state_d = ST_ABSENT;
          timer_d = '0;
        end else if (reset_req[gi] &&
                     (state_q == ST_RESET || state_q == ST_INIT || state_q == ST_READY)) begin
          state_d = ST_RESET;
          timer_d = '0;
        end
      end

      // Outputs are decoded from the next state so they change on the same edge.
      present_d = (state_d == ST_RESET) || (state_d == ST_INIT) || (state_d == ST_READY);
      ready_d   = (state_d == ST_READY);
      resetl_d  = (state_d != ST_ABSENT) && (state_d != ST_RESET);
      lpmode_d  = ready_d ? lpmode_req[gi] : 1'b1;
      modsell_d = !(sel_req[gi] && present_d);
      intp_d    = ready_d && !int_s_q;
    end

    assign qsfp_resetl[gi]    = resetl_q;
    assign qsfp_lpmode[gi]    = lpmode_q;
    assign qsfp_modsell[gi]   = modsell_q;
    assign present[gi]        = present_q;
    assign ready[gi]          = ready_q;
    assign int_pending[gi]    = intp_q;
    assign state[3*gi +: 3]   = state_q;
  end

endmodule

// File: tb/tb_taxi_qsfp_mod_ctrl.sv
// Bench for taxi_qsfp_mod_ctrl: vector table for insertion timing, hand sequences
// for the corner cases, then random stimulus against a phase/age reference model.
module tb_taxi_qsfp_mod_ctrl;

  localparam int CNT = 2;
  localparam int DEB = 4;
  localparam int RST = 8;
  localparam int INI = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [CNT-1:0] en, rreq, lpreq, sel, prsl, intl;
  logic [CNT-1:0] q_resetl, q_lpmode, q_modsell, present, ready, int_pending;
  logic [3*CNT-1:0] state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  taxi_qsfp_mod_ctrl #(
    .CNT(CNT), .DEBOUNCE_CYC(DEB), .RESET_CYC(RST), .INIT_CYC(INI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .enable(en), .reset_req(rreq), .lpmode_req(lpreq), .sel_req(sel),
    .qsfp_modprsl(prsl), .qsfp_intl(intl),
    .qsfp_resetl(q_resetl), .qsfp_lpmode(q_lpmode), .qsfp_modsell(q_modsell),
    .present(present), .ready(ready), .int_pending(int_pending), .state(state)
  );

  // Reference model: a cage is either absent or has an "age" counted from the
  // first debounce cycle; the phase follows from cumulative window thresholds.
  bit [1:0]   m_abs;
  int         m_age [CNT];
  logic [1:0] m_s1p, m_sp, m_s1i, m_si;
  logic [1:0] e_resetl, e_lpmode, e_modsell, e_present, e_ready, e_int;
  logic [2:0] e_state [CNT];

  function automatic logic [2:0] phase(int c);
    if (m_abs[c]) return 3'd0;
    if (m_age[c] < DEB) return 3'd1;
    if (m_age[c] < DEB + RST) return 3'd2;
    if (m_age[c] < DEB + RST + INI) return 3'd3;
    return 3'd4;
  endfunction

  task automatic model_reset();
    m_abs = 2'b11;
    m_s1p = 2'b11; m_sp = 2'b11; m_s1i = 2'b11; m_si = 2'b11;
    e_resetl = 2'b00; e_lpmode = 2'b11; e_modsell = 2'b11;
    e_present = 2'b00; e_ready = 2'b00; e_int = 2'b00;
    for (int c = 0; c < CNT; c++) begin
      m_age[c] = 0;
      e_state[c] = 3'd0;
    end
  endtask

  task automatic model_edge();
    logic [2:0] st;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int c = 0; c < CNT; c++) begin
      if (!m_abs[c]) begin
        if (m_sp[c] || !en[c]) m_abs[c] = 1'b1;
        else if (rreq[c] && m_age[c] >= DEB) m_age[c] = DEB;
        else if (m_age[c] < 1000) m_age[c] = m_age[c] + 1;
      end else if (en[c] && !m_sp[c]) begin
        m_abs[c] = 1'b0;
        m_age[c] = 0;
      end
      st = phase(c);
      e_state[c]   = st;
      e_present[c] = (st >= 3'd2);
      e_ready[c]   = (st == 3'd4);
      e_resetl[c]  = (st != 3'd0) && (st != 3'd2);
      e_lpmode[c]  = (st == 3'd4) ? lpreq[c] : 1'b1;
      e_modsell[c] = !(sel[c] && st >= 3'd2);
      e_int[c]     = (st == 3'd4) && !m_si[c];
    end
    m_sp = m_s1p; m_s1p = prsl;
    m_si = m_s1i; m_s1i = intl;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(int n);
    logic [17:0] act, exp;
    repeat (n) begin
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      act = {q_resetl, q_lpmode, q_modsell, present, ready, int_pending, state};
      exp = {e_resetl, e_lpmode, e_modsell, e_present, e_ready, e_int, e_state[1], e_state[0]};
      chk("model", 32'(act), 32'(exp));
    end
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, "_resetl"},  q_resetl,    2'b00);
    chk({tag, "_lpmode"},  q_lpmode,    2'b11);
    chk({tag, "_modsell"}, q_modsell,   2'b11);
    chk({tag, "_present"}, present,     2'b00);
    chk({tag, "_ready"},   ready,       2'b00);
    chk({tag, "_int"},     int_pending, 2'b00);
    chk({tag, "_state"},   state,       6'd0);
  endtask

  typedef struct {
    int         n;
    logic [1:0] en;
    logic [1:0] prsl;
    logic [2:0] st0;
    logic       resetl0;
    logic       present0;
    logic       ready0;
    logic       lpmode0;
    logic [2:0] st1;
    logic       resetl1;
  } vec_t;

  vec_t vecs [9];

  initial begin
    en = '0; rreq = '0; lpreq = '0; sel = '0; prsl = 2'b11; intl = 2'b11;
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    en = 2'b11;
    step(3);

    // Insertion of cage 0; cumulative edge counts 1,2,3,6,7,14,15,30,31.
    vecs[0] = '{1,  2'b11, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[1] = '{1,  2'b11, 2'b10, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[2] = '{1,  2'b11, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[3] = '{3,  2'b11, 2'b10, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[4] = '{1,  2'b11, 2'b10, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[5] = '{7,  2'b11, 2'b10, 3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[6] = '{1,  2'b11, 2'b10, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[7] = '{15, 2'b11, 2'b10, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    vecs[8] = '{1,  2'b11, 2'b10, 3'd4, 1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      en = vecs[i].en;
      prsl = vecs[i].prsl;
      step(vecs[i].n);
      chk("vec_state0",   state[2:0],  vecs[i].st0);
      chk("vec_resetl0",  q_resetl[0], vecs[i].resetl0);
      chk("vec_present0", present[0],  vecs[i].present0);
      chk("vec_ready0",   ready[0],    vecs[i].ready0);
      chk("vec_lpmode0",  q_lpmode[0], vecs[i].lpmode0);
      chk("vec_state1",   state[5:3],  vecs[i].st1);
      chk("vec_resetl1",  q_resetl[1], vecs[i].resetl1);
      $display("vec %0d cyc %0d: state0=%0d resetl0=%b present0=%b ready0=%b state1=%0d",
               i, cyc, state[2:0], q_resetl[0], present[0], ready[0], state[5:3]);
    end

    // lpmode follows request with one cycle lag; interrupt path latency.
    sel[0] = 1'b1; step(1); chk("modsell_sel", q_modsell[0], 1'b0);
    lpreq[0] = 1'b1; chk("lp_before", q_lpmode[0], 1'b0);
    step(1); chk("lp_follow1", q_lpmode[0], 1'b1);
    lpreq[0] = 1'b0; step(1); chk("lp_follow0", q_lpmode[0], 1'b0);
    intl[0] = 1'b0; step(2); chk("int_lag2", int_pending[0], 1'b0);
    step(1); chk("int_lag3", int_pending[0], 1'b1);
    intl[0] = 1'b1; step(2); chk("int_hold", int_pending[0], 1'b1);
    step(1); chk("int_clear", int_pending[0], 1'b0);
    $display("seq lpmode/int done cyc %0d", cyc);

    // reset_req pulse in READY.
    rreq[0] = 1'b1; step(1); rreq[0] = 1'b0;
    chk("rr_ready", ready[0], 1'b0);
    chk("rr_state", state[2:0], 3'd2);
    chk("rr_resetl", q_resetl[0], 1'b0);
    chk("rr_present", present[0], 1'b1);
    step(7); chk("rr_resetl_hold", q_resetl[0], 1'b0);
    step(1); chk("rr_resetl_rel", q_resetl[0], 1'b1); chk("rr_init", state[2:0], 3'd3);
    intl[0] = 1'b0; step(15);
    chk("int_in_init", int_pending[0], 1'b0); chk("rr_ready_wait", ready[0], 1'b0);
    intl[0] = 1'b1; step(1); chk("rr_ready_again", ready[0], 1'b1);
    step(3);
    $display("seq reset_req done cyc %0d", cyc);

    // Module removal in READY.
    prsl[0] = 1'b1; step(2); chk("rm_ready_e2", ready[0], 1'b1);
    step(1);
    chk("rm_ready", ready[0], 1'b0);
    chk("rm_resetl", q_resetl[0], 1'b0);
    chk("rm_lpmode", q_lpmode[0], 1'b1);
    chk("rm_modsell", q_modsell[0], 1'b1);
    chk("rm_state", state[2:0], 3'd0);
    $display("seq removal done cyc %0d", cyc);

    // One-cycle presence glitch during DEBOUNCE.
    prsl[0] = 1'b0; step(3); chk("gl_deb", state[2:0], 3'd1);
    prsl[0] = 1'b1; step(1); prsl[0] = 1'b0;
    chk("gl_e4", state[2:0], 3'd1); chk("gl_e4_resetl", q_resetl[0], 1'b1);
    step(1); chk("gl_e5", state[2:0], 3'd1);
    step(1); chk("gl_absent", state[2:0], 3'd0);
    step(1); chk("gl_restart", state[2:0], 3'd1);
    $display("seq glitch done cyc %0d", cyc);

    // Asynchronous reset while in INIT, then full re-run.
    step(12); chk("ar_init", state[2:0], 3'd3);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("arst");
    model_reset();
    step(2);
    rst_n = 1'b1;
    step(30); chk("ar_rerun_init", state[2:0], 3'd3); chk("ar_rerun_wait", ready[0], 1'b0);
    step(1); chk("ar_rerun_ready", ready[0], 1'b1);
    $display("seq async reset done cyc %0d", cyc);

    // Random stimulus on both cages, checked every cycle by the model.
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CNT; c++) begin
        en[c]    = ($urandom_range(0, 99) >= 2);
        rreq[c]  = ($urandom_range(0, 99) < 2);
        lpreq[c] = 1'($urandom_range(0, 1));
        sel[c]   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 99) < 2)  prsl[c] = ~prsl[c];
        if ($urandom_range(0, 99) < 10) intl[c] = ~intl[c];
      end
      step(1);
    end
    $display("random phase done cyc %0d", cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
